// File: rtl/ov7670_pkg.sv
// Shared constants and FSM state type for the OV7670 SCCB configuration block.
package ov7670_pkg;

    localparam logic [15:0] SCCB_ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] SCCB_ENTRY_DELAY = 16'hFFF0;
    localparam logic [7:0]  DEV_ID_DEFAULT   = 8'h42;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_FETCH,
        ST_START,
        ST_SEND,
        ST_STOP,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } sccb_state_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous register table for the OV7670: RGB444 output at QVGA, terminated by END.
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int ROM_AW   = 8,
    parameter bit TEST_ROM = 1'b0
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    function automatic logic [15:0] camera_entry(input int idx);
        case (idx)
            0:  return 16'h1280;             // COM7 soft reset
            1:  return SCCB_ENTRY_DELAY;     // camera needs ~1 ms after soft reset
            2:  return 16'h1214;
            3:  return 16'h8C02;
            4:  return 16'h0400;
            5:  return 16'h40D0;
            6:  return 16'h3A04;
            7:  return 16'h1418;
            8:  return 16'h4FB3;
            9:  return 16'h50B3;
            10: return 16'h5100;
            11: return 16'h523D;
            12: return 16'h53A7;
            13: return 16'h54E4;
            14: return 16'h589E;
            15: return 16'h3DC0;
            16: return 16'h1101;
            17: return 16'h1716;
            18: return 16'h1804;
            19: return 16'h3224;
            20: return 16'h1902;
            21: return 16'h1A7A;
            22: return 16'h030A;
            23: return 16'h0C04;
            24: return 16'h3E19;
            25: return 16'h703A;
            26: return 16'h7135;
            27: return 16'h7211;
            28: return 16'h73F1;
            29: return 16'hA202;
            default: return SCCB_ENTRY_END;
        endcase
    endfunction

    function automatic logic [15:0] test_entry(input int idx);
        case (idx)
            0: return 16'h1280;
            1: return SCCB_ENTRY_DELAY;
            2: return 16'h40D0;
            default: return SCCB_ENTRY_END;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        data <= TEST_ROM ? test_entry(int'(addr)) : camera_entry(int'(addr));
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Powers up the OV7670 and writes its register table over SCCB (ID, register, value per write).
// state | meaning
// PWRUP | post-reset wait, cam_reset_n released halfway through
// FETCH | two-cycle synchronous table read and decode
// START | SIOD low while SIOC high, two quarters
// SEND  | 27 bits: ID, reg, val, each followed by a released don't-care bit
// STOP  | SIOD low with SIOC low, then SIOC high, then SIOD released
// GAP   | four idle bit times before the next entry
// WAIT  | table-requested delay with the bus released
// DONE  | table exhausted, waiting for resend
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int          DIV_QTR      = 125,
    parameter int          PWRUP_CYCLES = 1_000_000,
    parameter int          DELAY_CYCLES = 50_000,
    parameter logic [7:0]  DEV_ID       = DEV_ID_DEFAULT,
    parameter int          ROM_AW       = 8,
    parameter bit          TEST_ROM     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              resend,
    output logic              sioc,
    output logic              siod_o,
    output logic              siod_t,
    output logic              cam_reset_n,
    output logic              cam_pwdn,
    output logic              busy,
    output logic              config_done,
    output logic [ROM_AW-1:0] reg_index
);

    localparam int TMAX = (PWRUP_CYCLES > DELAY_CYCLES) ? PWRUP_CYCLES : DELAY_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int QW   = $clog2(DIV_QTR + 1);

    localparam logic [TW-1:0]     PWRUP_LOAD = TW'(PWRUP_CYCLES - 1);
    localparam logic [TW-1:0]     RSTN_RISE  = TW'(PWRUP_CYCLES - PWRUP_CYCLES / 2);
    localparam logic [TW-1:0]     DELAY_LOAD = TW'(DELAY_CYCLES - 1);
    localparam logic [QW-1:0]     QTR_LOAD   = QW'(DIV_QTR - 1);
    localparam logic [ROM_AW-1:0] IDX_LAST   = '1;

    sccb_state_t  state;
    logic [TW-1:0] timer;
    logic [QW-1:0] qcnt;
    logic [3:0]    qidx;
    logic          fetch_ph;
    logic [3:0]    bit_cnt;
    logic [1:0]    phase;
    logic [23:0]   shreg;
    logic [15:0]   rom_data;
    logic          qtick;

    assign qtick    = (qcnt == '0);
    assign cam_pwdn = 1'b0;

    ov7670_reg_rom #(
        .ROM_AW   (ROM_AW),
        .TEST_ROM (TEST_ROM)
    ) u_rom (
        .clk  (clk),
        .addr (reg_index),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PWRUP;
            timer       <= PWRUP_LOAD;
            qcnt        <= QTR_LOAD;
            qidx        <= '0;
            fetch_ph    <= 1'b0;
            bit_cnt     <= '0;
            phase       <= '0;
            shreg       <= '0;
            sioc        <= 1'b1;
            siod_o      <= 1'b1;
            siod_t      <= 1'b1;
            cam_reset_n <= 1'b0;
            busy        <= 1'b1;
            config_done <= 1'b0;
            reg_index   <= '0;
        end else begin
            case (state)
                ST_PWRUP: begin
                    if (timer <= RSTN_RISE) cam_reset_n <= 1'b1;
                    if (timer == '0) begin
                        state     <= ST_FETCH;
                        reg_index <= '0;
                        fetch_ph  <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    if (fetch_ph) begin
                        if (rom_data == SCCB_ENTRY_END) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            config_done <= 1'b1;
                        end else if (rom_data == SCCB_ENTRY_DELAY) begin
                            if (reg_index == IDX_LAST) begin
                                state       <= ST_DONE;
                                busy        <= 1'b0;
                                config_done <= 1'b1;
                            end else begin
                                reg_index <= reg_index + ROM_AW'(1);
                                timer     <= DELAY_LOAD;
                                state     <= ST_WAIT;
                            end
                        end else begin
                            state  <= ST_START;
                            shreg  <= {DEV_ID, rom_data};
                            siod_t <= 1'b0;
                            siod_o <= 1'b0;
                            qcnt   <= QTR_LOAD;
                            qidx   <= '0;
                        end
                    end
                end
                ST_START: begin
                    if (qtick) begin
                        qcnt <= QTR_LOAD;
                        if (qidx == 4'd1) begin
                            state   <= ST_SEND;
                            qidx    <= '0;
                            bit_cnt <= '0;
                            phase   <= '0;
                            sioc    <= 1'b0;
                            siod_o  <= shreg[23];
                            shreg   <= {shreg[22:0], 1'b0};
                        end else begin
                            qidx <= qidx + 4'd1;
                        end
                    end else begin
                        qcnt <= qcnt - QW'(1);
                    end
                end
                ST_SEND: begin
                    if (qtick) begin
                        qcnt <= QTR_LOAD;
                        qidx <= qidx + 4'd1;
                        if (qidx == 4'd1) sioc <= 1'b1;
                        // end of a bit: SIOC falls and the next bit goes out on the same edge
                        if (qidx == 4'd3) begin
                            qidx <= '0;
                            sioc <= 1'b0;
                            if (bit_cnt == 4'd8) begin
                                if (phase == 2'd2) begin
                                    state  <= ST_STOP;
                                    siod_t <= 1'b0;
                                    siod_o <= 1'b0;
                                end else begin
                                    phase   <= phase + 2'd1;
                                    bit_cnt <= '0;
                                    siod_t  <= 1'b0;
                                    siod_o  <= shreg[23];
                                    shreg   <= {shreg[22:0], 1'b0};
                                end
                            end else if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                siod_t  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                siod_o  <= shreg[23];
                                shreg   <= {shreg[22:0], 1'b0};
                            end
                        end
                    end else begin
                        qcnt <= qcnt - QW'(1);
                    end
                end
                ST_STOP: begin
                    if (qtick) begin
                        qcnt <= QTR_LOAD;
                        if (qidx == 4'd0) begin
                            sioc <= 1'b1;
                            qidx <= 4'd1;
                        end else begin
                            siod_t <= 1'b1;
                            siod_o <= 1'b1;
                            qidx   <= '0;
                            state  <= ST_GAP;
                        end
                    end else begin
                        qcnt <= qcnt - QW'(1);
                    end
                end
                ST_GAP: begin
                    if (qtick) begin
                        qcnt <= QTR_LOAD;
                        if (qidx == 4'd15) begin
                            qidx <= '0;
                            // running off the end of the table counts as END
                            if (reg_index == IDX_LAST) begin
                                state       <= ST_DONE;
                                busy        <= 1'b0;
                                config_done <= 1'b1;
                            end else begin
                                reg_index <= reg_index + ROM_AW'(1);
                                fetch_ph  <= 1'b0;
                                state     <= ST_FETCH;
                            end
                        end else begin
                            qidx <= qidx + 4'd1;
                        end
                    end else begin
                        qcnt <= qcnt - QW'(1);
                    end
                end
                ST_WAIT: begin
                    if (timer == '0) begin
                        fetch_ph <= 1'b0;
                        state    <= ST_FETCH;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_DONE: begin
                    if (resend) begin
                        state       <= ST_FETCH;
                        reg_index   <= '0;
                        fetch_ph    <= 1'b0;
                        busy        <= 1'b1;
                        config_done <= 1'b0;
                    end
                end
                default: state <= ST_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: per-cycle waveform model built from the table, plus an SCCB decoder.
`timescale 1ns/1ps
module tb_ov7670_sccb_config;

    localparam int Q   = 2;
    localparam int PW  = 16;
    localparam int DLY = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       resend;
    logic       sioc, siod_o, siod_t, cam_reset_n, cam_pwdn, busy, config_done;
    logic [7:0] reg_index;
    logic       bus_now;

    always #5 clk = ~clk;
    assign bus_now = siod_t ? 1'b1 : siod_o;

    ov7670_sccb_config #(
        .DIV_QTR      (Q),
        .PWRUP_CYCLES (PW),
        .DELAY_CYCLES (DLY),
        .DEV_ID       (8'h42),
        .ROM_AW       (8),
        .TEST_ROM     (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .resend      (resend),
        .sioc        (sioc),
        .siod_o      (siod_o),
        .siod_t      (siod_t),
        .cam_reset_n (cam_reset_n),
        .cam_pwdn    (cam_pwdn),
        .busy        (busy),
        .config_done (config_done),
        .reg_index   (reg_index)
    );

    typedef struct packed {
        logic       sioc;
        logic       bus;
        logic       rel;
        logic       busy;
        logic       done;
        logic       crn;
        logic       pwdn;
        logic [7:0] idx;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] mon_bytes[$];
    logic [15:0] tbl[4];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
        end
    endtask

    // ---------------- waveform model ----------------
    function automatic void push_n(int n, logic s, logic b, logic r, logic bz, logic dn, logic crn, int idx);
        obs_t o;
        o.sioc = s; o.bus = b; o.rel = r; o.busy = bz; o.done = dn;
        o.crn = crn; o.pwdn = 1'b0; o.idx = 8'(idx);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    function automatic void push_write(logic [15:0] e, int idx);
        logic [7:0] by[3];
        logic bv;
        by[0] = 8'h42; by[1] = e[15:8]; by[2] = e[7:0];
        push_n(2*Q, 1, 0, 0, 1, 0, 1, idx);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 9; b++) begin
                if (b < 8) begin
                    bv = by[p][7-b];
                    push_n(2*Q, 0, bv, 0, 1, 0, 1, idx);
                    push_n(2*Q, 1, bv, 0, 1, 0, 1, idx);
                end else begin
                    push_n(2*Q, 0, 1, 1, 1, 0, 1, idx);
                    push_n(2*Q, 1, 1, 1, 1, 0, 1, idx);
                end
            end
        end
        push_n(Q, 0, 0, 0, 1, 0, 1, idx);
        push_n(Q, 1, 0, 0, 1, 0, 1, idx);
        push_n(16*Q, 1, 1, 1, 1, 0, 1, idx);
        for (int p = 0; p < 3; p++) exp_bytes.push_back(by[p]);
    endfunction

    function automatic void build(bit pwrup, int n_done);
        int idx;
        bit fin;
        idx = 0;
        fin = 1'b0;
        if (pwrup) begin
            push_n(PW/2, 1, 1, 1, 1, 0, 0, 0);
            push_n(PW - PW/2, 1, 1, 1, 1, 0, 1, 0);
        end
        for (int g = 0; g < 16 && !fin; g++) begin
            push_n(2, 1, 1, 1, 1, 0, 1, idx);
            if (tbl[idx] == 16'hFFFF) begin
                push_n(n_done, 1, 1, 1, 0, 1, 1, idx);
                fin = 1'b1;
            end else if (tbl[idx] == 16'hFFF0) begin
                idx++;
                push_n(DLY, 1, 1, 1, 1, 0, 1, idx);
            end else begin
                push_write(tbl[idx], idx);
                idx++;
            end
        end
    endfunction

    obs_t act_o, exp_o;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o.sioc = sioc; act_o.bus = bus_now; act_o.rel = siod_t;
            act_o.busy = busy; act_o.done = config_done; act_o.crn = cam_reset_n;
            act_o.pwdn = cam_pwdn; act_o.idx = reg_index;
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                if (failures <= 25)
                    $display("FAIL cycle_model got=%h want=%h t=%0t", act_o, exp_o, $time);
            end
        end
    end

    // ---------------- SCCB decoder ----------------
    logic       prev_sioc = 1'b1, prev_bus = 1'b1;
    bit         mon_in_xfer = 1'b0;
    int         mon_bits = 0;
    int         mon_stops = 0;
    int         first_fall = -1;
    int         rel_cyc = 0;
    logic [7:0] cur_byte;
    logic [7:0] tbuf[$];
    int         start_cyc[$];
    int         stop_cyc[$];

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mon_in_xfer = 1'b0;
            mon_bits    = 0;
            tbuf.delete();
            prev_sioc   = 1'b1;
            prev_bus    = 1'b1;
        end else begin
            if (prev_sioc && sioc && prev_bus && !bus_now) begin
                mon_in_xfer = 1'b1;
                mon_bits    = 0;
                tbuf.delete();
                start_cyc.push_back(cyc);
            end else if (prev_sioc && sioc && !prev_bus && bus_now) begin
                if (mon_in_xfer) begin
                    checks++;
                    if (tbuf.size() != 3) begin
                        failures++;
                        $display("FAIL stop_bytes got=%0d want=3", tbuf.size());
                    end
                    foreach (tbuf[i]) mon_bytes.push_back(tbuf[i]);
                end
                mon_in_xfer = 1'b0;
                mon_stops++;
                stop_cyc.push_back(cyc);
            end else if (!prev_sioc && sioc && mon_in_xfer) begin
                if ((mon_bits % 9) < 8) begin
                    cur_byte = {cur_byte[6:0], bus_now};
                end else begin
                    tbuf.push_back(cur_byte);
                    checks++;
                    if (siod_t !== 1'b1) begin
                        failures++;
                        $display("FAIL ninth_bit_release got=%b want=1", siod_t);
                    end
                end
                mon_bits++;
            end
            if (prev_sioc && !sioc && first_fall < 0) first_fall = cyc - rel_cyc;
            prev_sioc = sioc;
            prev_bus  = bus_now;
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic cmp_bytes(input string nm);
        chk({nm, "_count"}, mon_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < mon_bytes.size(); i++)
            chk(nm, mon_bytes[i], exp_bytes[i]);
    endtask

    logic [7:0] lit_bytes[6];
    int saved;

    initial begin
        tbl[0] = 16'h1280; tbl[1] = 16'hFFF0; tbl[2] = 16'h40D0; tbl[3] = 16'hFFFF;
        lit_bytes[0] = 8'h42; lit_bytes[1] = 8'h12; lit_bytes[2] = 8'h80;
        lit_bytes[3] = 8'h42; lit_bytes[4] = 8'h40; lit_bytes[5] = 8'hD0;
        rst_n  = 1'b0;
        resend = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sioc", sioc, 1);
        chk("rst_siod_o", siod_o, 1);
        chk("rst_siod_t", siod_t, 1);
        chk("rst_cam_reset_n", cam_reset_n, 0);
        chk("rst_cam_pwdn", cam_pwdn, 0);
        chk("rst_busy", busy, 1);
        chk("rst_config_done", config_done, 0);
        chk("rst_reg_index", reg_index, 0);

        build(1'b1, 1000);
        void'(exp_q.pop_front());
        rel_cyc = cyc;
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("crn_low_clk7", cam_reset_n, 0);
        @(negedge clk);
        chk("crn_high_clk8", cam_reset_n, 1);
        wait_drain(3000);

        chk("first_fall_min16", (first_fall >= 16) ? 1 : 0, 1);
        chk("first_fall_clk", first_fall, 22);
        chk("end_done", config_done, 1);
        chk("end_busy", busy, 0);
        chk("end_reg_index", reg_index, 3);
        chk("end_stops", mon_stops, 2);
        chk("lit_byte_count", mon_bytes.size(), 6);
        for (int i = 0; i < 6 && i < mon_bytes.size(); i++) chk("lit_byte", mon_bytes[i], lit_bytes[i]);
        if (start_cyc.size() >= 2 && stop_cyc.size() >= 1)
            chk("delay_idle_min20", ((start_cyc[1] - stop_cyc[0]) >= 20) ? 1 : 0, 1);
        else
            chk("delay_idle_edges", start_cyc.size(), 2);

        // resend in DONE, then a pulse while busy that must be ignored
        @(negedge clk);
        build(1'b0, 50);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        chk("resend_done_clr", config_done, 0);
        chk("resend_busy", busy, 1);
        repeat (100) @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_drain(3000);
        chk("resend_stops", mon_stops, 4);
        cmp_bytes("resend_bytes");

        // reset in the middle of the register byte
        @(negedge clk);
        saved = exp_bytes.size();
        build(1'b0, 50);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        for (int i = 0; i < 2000 && !(mon_in_xfer && mon_bits == 13); i++) @(negedge clk);
        chk("abort_reached", mon_bits, 13);
        exp_q.delete();
        while (exp_bytes.size() > saved) void'(exp_bytes.pop_back());
        #1 rst_n = 1'b0;
        #1;
        chk("abort_sioc", sioc, 1);
        chk("abort_siod_t", siod_t, 1);
        chk("abort_busy", busy, 1);
        chk("abort_config_done", config_done, 0);
        chk("abort_cam_reset_n", cam_reset_n, 0);
        chk("abort_reg_index", reg_index, 0);
        repeat (2) @(negedge clk);
        build(1'b1, 50);
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        wait_drain(3000);
        chk("abort_stops", mon_stops, 6);
        cmp_bytes("abort_bytes");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
